// File: rtl/nld_pkg.sv
// Shared types and helpers for the nonlinear distortion pipeline model.
package nld_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    NLD_BYPASS = 2'd0,
    NLD_RAIL   = 2'd1,
    NLD_ENV    = 2'd2,
    NLD_CLIP   = 2'd3
  } nld_mode_e;

  typedef struct packed {
    logic signed [31:0] val;
    logic               clip;
  } rs_t;

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Round to nearest (ties away from zero), then saturate to a w-bit signed range.
  function automatic rs_t round_sat(input real v, input int unsigned w);
    rs_t r;
    real rr;
    real hi;
    real lo;
    r  = '0;
    hi = real'((64'sd1 <<< (w - 1)) - 64'sd1);
    lo = -real'(64'sd1 <<< (w - 1));
    rr = (v >= 0.0) ? $floor(v + 0.5) : -$floor(0.5 - v);
    if (rr > hi) begin
      rr     = hi;
      r.clip = 1'b1;
    end else if (rr < lo) begin
      rr     = lo;
      r.clip = 1'b1;
    end
    r.val = 32'($rtoi(rr));
    return r;
  endfunction

endpackage

// File: rtl/nonlinear_distortion_pipe_mdl_stage.sv
// One enabled pipeline register carrying valid, I/Q, mode and clip flag.
module nld_stage
  import nld_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                src_valid,
  input  logic signed [W-1:0] src_i,
  input  logic signed [W-1:0] src_q,
  input  nld_mode_e           src_mode,
  input  logic                src_clip,
  output logic                valid,
  output logic signed [W-1:0] i,
  output logic signed [W-1:0] q,
  output nld_mode_e           mode,
  output logic                clip
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      i     <= '0;
      q     <= '0;
      mode  <= NLD_BYPASS;
      clip  <= 1'b0;
    end else if (en) begin
      valid <= src_valid;
      i     <= src_i;
      q     <= src_q;
      mode  <= src_mode;
      clip  <= src_clip;
    end
  end

endmodule

// File: rtl/nonlinear_distortion_pipe_mdl.sv
// I/Q nonlinear distortion behavioural pipeline: bypass, per-rail/envelope compression, hard clip.
// Optional AM/PM rotation for modes 1/2 is built when NLD_AMPM_EN is defined.
module nonlinear_distortion_pipe_mdl
  import nld_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter int unsigned LAT      = 3,
  parameter real         ALPHA    = 1.0e-9,
  parameter real         P        = 2.0,
  parameter longint      CLIP_LVL = (64'sd1 <<< (W - 1)) - 64'sd1,
  parameter real         BETA     = 0.0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] i_in,
  input  logic signed [W-1:0] q_in,
  input  logic [1:0]          mode,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [W-1:0] i_out,
  output logic signed [W-1:0] q_out,
  input  logic                clr_cnt,
  output logic [CNT_W-1:0]    clip_cnt,
  output logic [CNT_W-1:0]    smp_cnt
);

  localparam int NST = int'(LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                en;
  logic                vld [NST];
  logic signed [W-1:0] si  [NST];
  logic signed [W-1:0] sq  [NST];
  nld_mode_e           sm  [NST];
  logic                sc  [NST];

  nld_mode_e           nxt_mode;
  logic signed [W-1:0] nxt_i;
  logic signed [W-1:0] nxt_q;
  logic                nxt_clip;
  real                 ri, rq, env, yi, yq, g;
  rs_t                 res_i, res_q;
  longint              li, lq;

  assign en      = !m_valid || m_ready;
  assign s_ready = en;

`ifdef NLD_AMPM_EN
  localparam real FS = real'(64'sd1 <<< (W - 1));
  real phi, ti, tq;
`else
  // BETA has no effect without the AM/PM rotation.
  if (BETA != 0.0) begin : g_beta_ignored
  end
`endif

  // Distortion applied at acceptance; the result then rides the register chain.
  always_comb begin
    nxt_mode = nld_mode_e'(mode);
    nxt_i    = i_in;
    nxt_q    = q_in;
    nxt_clip = 1'b0;
    ri       = real'(i_in);
    rq       = real'(q_in);
    env      = $sqrt(ri * ri + rq * rq);
    yi       = ri;
    yq       = rq;
    g        = 1.0;
    res_i    = '0;
    res_q    = '0;
    li       = longint'(i_in);
    lq       = longint'(q_in);
`ifdef NLD_AMPM_EN
    phi      = 0.0;
    ti       = 0.0;
    tq       = 0.0;
`endif
    case (nxt_mode)
      NLD_RAIL, NLD_ENV: begin
        if (nxt_mode == NLD_RAIL) begin
          yi = ri / (1.0 + ALPHA * (rabs(ri) ** P));
          yq = rq / (1.0 + ALPHA * (rabs(rq) ** P));
        end else if (env == 0.0) begin
          yi = 0.0;
          yq = 0.0;
        end else begin
          g  = 1.0 / (1.0 + ALPHA * (env ** P));
          yi = ri * g;
          yq = rq * g;
        end
`ifdef NLD_AMPM_EN
        phi = BETA * (env / FS) * (env / FS);
        ti  = yi * $cos(phi) - yq * $sin(phi);
        tq  = yi * $sin(phi) + yq * $cos(phi);
        yi  = ti;
        yq  = tq;
`endif
        res_i    = round_sat(yi, W);
        res_q    = round_sat(yq, W);
        nxt_i    = W'(res_i.val);
        nxt_q    = W'(res_q.val);
        nxt_clip = res_i.clip | res_q.clip;
      end
      NLD_CLIP: begin
        if (li > CLIP_LVL) begin
          nxt_i    = W'(CLIP_LVL);
          nxt_clip = 1'b1;
        end else if (li < -CLIP_LVL) begin
          nxt_i    = W'(-CLIP_LVL);
          nxt_clip = 1'b1;
        end
        if (lq > CLIP_LVL) begin
          nxt_q    = W'(CLIP_LVL);
          nxt_clip = 1'b1;
        end else if (lq < -CLIP_LVL) begin
          nxt_q    = W'(-CLIP_LVL);
          nxt_clip = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  for (genvar k = 0; k < NST; k++) begin : g_stage
    if (k == 0) begin : g_first
      nld_stage #(.W(W)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .src_valid(s_valid),
        .src_i    (nxt_i),
        .src_q    (nxt_q),
        .src_mode (nxt_mode),
        .src_clip (nxt_clip),
        .valid    (vld[k]),
        .i        (si[k]),
        .q        (sq[k]),
        .mode     (sm[k]),
        .clip     (sc[k])
      );
    end else begin : g_next
      nld_stage #(.W(W)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .src_valid(vld[k-1]),
        .src_i    (si[k-1]),
        .src_q    (sq[k-1]),
        .src_mode (sm[k-1]),
        .src_clip (sc[k-1]),
        .valid    (vld[k]),
        .i        (si[k]),
        .q        (sq[k]),
        .mode     (sm[k]),
        .clip     (sc[k])
      );
    end
  end

  assign m_valid = vld[NST-1];
  assign i_out   = si[NST-1];
  assign q_out   = sq[NST-1];

  // Transfer counters; clear wins over a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_cnt  <= '0;
      clip_cnt <= '0;
    end else if (clr_cnt) begin
      smp_cnt  <= '0;
      clip_cnt <= '0;
    end else if (m_valid && m_ready) begin
      if (smp_cnt != CNT_MAX) smp_cnt <= smp_cnt + CNT_W'(1);
      if (sc[NST-1] && clip_cnt != CNT_MAX) clip_cnt <= clip_cnt + CNT_W'(1);
    end
  end

  a_bypass_noclip: assert property (@(posedge clk) disable iff (reset)
    (m_valid && sm[NST-1] == NLD_BYPASS) |-> !sc[NST-1]);

endmodule
